// File: rtl/spi_poll_scheduler.sv
// Periodic sensor-poll sequencer: scans up to 4 SPI chip selects per period,
// runs a 3-byte read on each enabled sensor and emits a 16-bit result.
module spi_poll_scheduler #(
    parameter int          clk_freq = 50000000,
    parameter int          poll_hz  = 100,
    parameter logic [7:0]  CMD      = 8'h80,
    parameter int          CS_GAP   = 4,
    parameter int          TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  cs_mask,
    input  logic        clr_flags,
    output logic [3:0]  spi_cs,
    output logic        m_start,
    output logic [7:0]  m_txdata,
    input  logic        m_done,
    input  logic [7:0]  m_rxdata,
    output logic        res_valid,
    output logic [1:0]  res_idx,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int PERIOD = clk_freq / poll_hz;
    localparam int TW     = $clog2(PERIOD);
    localparam int GW     = $clog2(CS_GAP + 1);
    localparam int WW     = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SETUP, S_XFER, S_WAIT, S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      mask_q, mask_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      bc_q, bc_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [WW-1:0]   wc_q, wc_d;
    logic [3:0]      cs_q, cs_d;
    logic [7:0]      txd_q, txd_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      lo_q, lo_d;
    logic            err_q, err_d;
    logic            ovr_q, ovr_d;
    logic            terr_q, terr_d;

    logic            tick;
    logic            found;
    logic [1:0]      pick;
    logic            gap_last;

    assign tick     = (timer_q == TW'(PERIOD - 1));
    assign gap_last = (gap_q == GW'(CS_GAP - 1));

    // Lowest latched-mask index at or above the scan pointer.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) >= ptr_q)) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end

    // Next-state logic for timer, scan FSM and sticky flags.
    always_comb begin
        state_d = state_q;
        timer_d = tick ? '0 : timer_q + TW'(1);
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        bc_d    = bc_q;
        gap_d   = gap_q;
        wc_d    = wc_q;
        cs_d    = cs_q;
        txd_d   = txd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        terr_d  = clr_flags ? 1'b0 : terr_q;
        ovr_d   = clr_flags ? 1'b0 : ovr_q;

        if (tick && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (tick && enable && (cs_mask != 4'h0)) begin
                    mask_d  = cs_mask;
                    ptr_d   = 3'd0;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (found) begin
                    idx_d   = pick;
                    cs_d    = ~(4'b0001 << pick);
                    gap_d   = '0;
                    bc_d    = 2'd0;
                    err_d   = 1'b0;
                    hi_d    = 8'h00;
                    lo_d    = 8'h00;
                    state_d = S_SETUP;
                end else begin
                    ptr_d   = 3'd0;
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (gap_last) begin
                    txd_d   = CMD | {6'b0, idx_q};
                    state_d = S_XFER;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_XFER: begin
                wc_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    if (bc_q == 2'd1) hi_d = m_rxdata;
                    if (bc_q == 2'd2) lo_d = m_rxdata;
                    if (bc_q != 2'd2) begin
                        bc_d    = bc_q + 2'd1;
                        txd_d   = 8'h00;
                        state_d = S_XFER;
                    end else begin
                        cs_d    = 4'hF;
                        gap_d   = '0;
                        state_d = S_HOLD;
                    end
                end else if (wc_q == WW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    err_d   = 1'b1;
                    hi_d    = 8'h00;
                    lo_d    = 8'h00;
                    cs_d    = 4'hF;
                    gap_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    wc_d = wc_q + WW'(1);
                end
            end
            S_HOLD: begin
                if (gap_last) begin
                    ptr_d   = {1'b0, idx_q} + 3'd1;
                    state_d = S_SEL;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            mask_q  <= 4'h0;
            ptr_q   <= 3'd0;
            idx_q   <= 2'd0;
            bc_q    <= 2'd0;
            gap_q   <= '0;
            wc_q    <= '0;
            cs_q    <= 4'hF;
            txd_q   <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            bc_q    <= bc_d;
            gap_q   <= gap_d;
            wc_q    <= wc_d;
            cs_q    <= cs_d;
            txd_q   <= txd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            terr_q  <= terr_d;
        end
    end

    assign spi_cs      = cs_q;
    assign m_start     = (state_q == S_XFER);
    assign m_txdata    = txd_q;
    assign res_valid   = (state_q == S_HOLD) && gap_last;
    assign res_idx     = idx_q;
    assign res_data    = {hi_q, lo_q};
    assign res_err     = err_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = ovr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_spi_poll_scheduler.sv
// Scoreboard bench for spi_poll_scheduler with a simple SPI master model
// answering each byte 8 clocks after m_start.
module tb_spi_poll_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  cs_mask = 4'h0;
    logic        clr_flags = 1'b0;
    logic [3:0]  spi_cs;
    logic        m_start;
    logic [7:0]  m_txdata;
    logic        m_done = 1'b0;
    logic [7:0]  m_rxdata = 8'h00;
    logic        res_valid;
    logic [1:0]  res_idx;
    logic [15:0] res_data;
    logic        res_err;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    always #5 clk = ~clk;

    spi_poll_scheduler #(
        .clk_freq(1000),
        .poll_hz (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cs_mask    (cs_mask),
        .clr_flags  (clr_flags),
        .spi_cs     (spi_cs),
        .m_start    (m_start),
        .m_txdata   (m_txdata),
        .m_done     (m_done),
        .m_rxdata   (m_rxdata),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_data   (res_data),
        .res_err    (res_err),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  tx_q[$];
    logic [3:0]  csx_q[$];
    logic [18:0] res_q[$];

    logic       mdl_ack = 1'b1;
    logic       mdl_vary = 1'b0;
    int         mdl_cnt = 0;
    logic [1:0] mdl_b = 2'd0;
    logic [1:0] mdl_idx = 2'd0;

    function automatic logic [7:0] resp(input logic [1:0] b,
                                        input logic [1:0] i,
                                        input logic v);
        case (b)
            2'd0:    return 8'hAA;
            2'd1:    return v ? (8'h12 ^ {2'b0, i, 4'h0}) : 8'h12;
            default: return v ? (8'h34 + {6'b0, i}) : 8'h34;
        endcase
    endfunction

    // SPI master model.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            mdl_cnt <= 0;
        end else if (m_start) begin
            if (mdl_ack) mdl_cnt <= 8;
            if (m_txdata[7]) begin
                mdl_b   <= 2'd0;
                mdl_idx <= m_txdata[1:0];
            end else begin
                mdl_b <= mdl_b + 2'd1;
            end
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                m_done   <= 1'b1;
                m_rxdata <= resp(mdl_b, mdl_idx, mdl_vary);
            end
        end
    end

    int         cyc = 0;
    int         mstarts = 0;
    int         busy_cyc = 0;
    int         start_cyc = 0;
    logic [7:0] last_tx = 8'h00;
    logic       lat_chk = 1'b0;

    always @(posedge clk) cyc++;

    // Monitor: pop expectations as the DUT produces bytes and results.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cyc++;
            if (m_start) begin
                mstarts++;
                start_cyc = cyc;
                last_tx = m_txdata;
                if (tx_q.size() == 0) begin
                    chk("tx_unexp", tx_q.size(), 1);
                end else begin
                    chk("txdata", m_txdata, tx_q.pop_front());
                    chk("cs_at_start", spi_cs, csx_q.pop_front());
                end
            end
            if (m_done) chk("tx_stable", m_txdata, last_tx);
            if (res_valid) begin
                chk("cs_released", spi_cs, 4'hF);
                if (res_q.size() == 0) begin
                    chk("res_unexp", res_q.size(), 1);
                end else begin
                    chk("result", {res_err, res_idx, res_data},
                        res_q.pop_front());
                end
                if (lat_chk) chk("to_latency", cyc - start_cyc, 1028);
            end
        end
    end

    task automatic push_tx(input logic [1:0] i, input int n);
        for (int b = 0; b < n; b++) begin
            tx_q.push_back(b == 0 ? (8'h80 | {6'b0, i}) : 8'h00);
            csx_q.push_back(~(4'b0001 << i));
        end
    endtask

    task automatic push_ok(input logic [1:0] i, input logic v);
        push_tx(i, 3);
        res_q.push_back({1'b0, i, resp(2'd1, i, v), resp(2'd2, i, v)});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input int lim);
        int n = 0;
        while (busy !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(lvl ? "busy_rise" : "busy_fall", busy, lvl);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_txq"}, tx_q.size(), 0);
        chk({tag, "_resq"}, res_q.size(), 0);
    endtask

    initial begin
        int m0;
        int b0;
        int n;

        // Reset with enable low: idle, nothing started.
        cycles(5);
        chk("rst_cs", spi_cs, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_mstart", m_start, 0);
        chk("rst_txdata", m_txdata, 0);
        chk("rst_res", {res_valid, res_err, res_idx, res_data}, 0);
        chk("rst_flags", {overrun, timeout_err}, 0);
        rst = 1'b0;
        cs_mask = 4'b0101;
        m0 = mstarts;
        b0 = busy_cyc;
        cycles(300);
        chk("t1_no_start", mstarts - m0, 0);
        chk("t1_no_busy", busy_cyc - b0, 0);

        // Two sensors, fixed response AA,12,34.
        push_ok(2'd0, 1'b0);
        push_ok(2'd2, 1'b0);
        enable = 1'b1;
        wait_busy(1'b1, 300);
        enable = 1'b0;
        wait_busy(1'b0, 400);
        cycles(5);
        chk_drained("t2");
        chk("t2_overrun", overrun, 0);
        chk("t2_timeout", timeout_err, 0);

        // Silent slave on sensor 3: timeout path.
        mdl_ack = 1'b0;
        cs_mask = 4'b1000;
        push_tx(2'd3, 1);
        res_q.push_back({1'b1, 2'd3, 16'h0000});
        lat_chk = 1'b1;
        enable = 1'b1;
        wait_busy(1'b1, 300);
        enable = 1'b0;
        wait_busy(1'b0, 1500);
        lat_chk = 1'b0;
        cycles(5);
        chk_drained("t3");
        chk("t3_cs", spi_cs, 4'hF);
        chk("t3_terr_set", timeout_err, 1);
        cycles(200);
        chk("t3_terr_sticky", timeout_err, 1);
        pulse_clr();
        chk("t3_terr_clr", timeout_err, 0);
        mdl_ack = 1'b1;

        // All four sensors: scan outlasts the period, two scans.
        mdl_vary = 1'b1;
        cs_mask = 4'hF;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) push_ok(2'(i), 1'b1);
        end
        enable = 1'b1;
        wait_busy(1'b1, 300);
        wait_busy(1'b0, 400);
        wait_busy(1'b1, 300);
        enable = 1'b0;
        wait_busy(1'b0, 400);
        cycles(5);
        chk_drained("t4");
        chk("t4_overrun", overrun, 1);
        pulse_clr();
        chk("t4_ovr_clr", overrun, 0);
        mdl_vary = 1'b0;

        // Reset during the wait of sensor 1.
        cs_mask = 4'b0011;
        push_ok(2'd0, 1'b0);
        push_tx(2'd1, 1);
        enable = 1'b1;
        wait_busy(1'b1, 300);
        enable = 1'b0;
        n = 0;
        while (!(m_start && m_txdata == 8'h81) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t5_s1_start", m_start, 1);
        cycles(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_cs", spi_cs, 4'hF);
        chk("t5_busy", busy, 0);
        chk("t5_resv", res_valid, 0);
        cycles(20);
        chk_drained("t5a");
        push_ok(2'd0, 1'b0);
        push_ok(2'd1, 1'b0);
        enable = 1'b1;
        wait_busy(1'b1, 300);
        enable = 1'b0;
        wait_busy(1'b0, 400);
        cycles(5);
        chk_drained("t5b");

        // Enabled with empty mask: ticks do nothing.
        cs_mask = 4'h0;
        enable = 1'b1;
        m0 = mstarts;
        b0 = busy_cyc;
        cycles(300);
        chk("t6_no_start", mstarts - m0, 0);
        chk("t6_no_busy", busy_cyc - b0, 0);
        chk("t6_busy", busy, 0);
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
